// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with live occupancy count, threshold flags,
// registered error pulses and selectable standard / first-word-fall-through read.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 wr_error,
    output logic                 rd_error
);

    localparam logic [PTR_WIDTH:0] DEPTH_LVL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_LVL    = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_LVL    = (PTR_WIDTH+1)'(AE_THRESH);
    localparam logic [PTR_WIDTH:0] ONE       = (PTR_WIDTH+1)'(1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] wptr_reg;
    logic [PTR_WIDTH:0] rptr_reg;
    logic [PTR_WIDTH:0] count_reg;
    logic               wr_error_reg;
    logic               rd_error_reg;
    logic               wr_accept;
    logic               rd_accept;

    // Flags decode from the count register alone, so they only move on an edge or reset.
    assign full         = (count_reg == DEPTH_LVL);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_LVL);
    assign almost_empty = (count_reg <= AE_LVL);
    assign count        = count_reg;
    assign wr_error     = wr_error_reg;
    assign rd_error     = rd_error_reg;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_reg[PTR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            wr_error_reg <= 1'b0;
            rd_error_reg <= 1'b0;
        end else begin
            wr_error_reg <= wr_en && full;
            rd_error_reg <= rd_en && empty;
            if (wr_accept) begin
                wptr_reg <= wptr_reg + ONE;
            end
            if (rd_accept) begin
                rptr_reg <= rptr_reg + ONE;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_reg <= count_reg + ONE;
                2'b01:   count_reg <= count_reg - ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented straight from the array; it is meaningless while empty.
            assign rd_data  = mem[rptr_reg[PTR_WIDTH-1:0]];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_reg;
            logic             rd_valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_accept;
                    if (rd_accept) begin
                        rd_data_reg <= mem[rptr_reg[PTR_WIDTH-1:0]];
                    end
                end
            end

            assign rd_data  = rd_data_reg;
            assign rd_valid = rd_valid_reg;
        end
    endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO for buffering data between producer and consumer stages in the same clock domain.
- Generalises the existing FIFO family in three ways:
  - configurable width, depth and almost-full/almost-empty thresholds;
  - a live occupancy count;
  - selectable standard or first-word-fall-through (FWFT) read mode.
- Keeps the family's full/empty flags and wr_error/rd_error signalling.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- PTR_WIDTH, $clog2(DEPTH), derived pointer width; not overridden.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request (in FWFT mode: pop/acknowledge).
- rd_data  output  WIDTH  read data.
- rd_valid  output  1  rd_data holds a valid word (see Behaviour).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- wr_error  output  1  registered pulse: a write was rejected.
- rd_error  output  1  registered pulse: a read was rejected.

Behaviour:
- Reset (async assert, sync release):
  - write pointer, read pointer and count = 0;
  - empty=1, almost_empty=1, full=0, almost_full=0;
  - wr_error=0, rd_error=0, rd_valid=0, rd_data=0 (FWFT=0);
  - memory array is not cleared.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Pointers are PTR_WIDTH+1 bits; the MSB is the wrap bit. Addressing uses the low PTR_WIDTH bits, with natural wrap at DEPTH.
- Status flags: full, empty, almost_full and almost_empty are decoded combinationally from the count register only, so they change only after a clock edge (or reset).
- Write acceptance:
  - Accepted iff wr_en && !full, evaluated on the pre-edge state.
  - On acceptance: mem[wptr] <= wr_data and wptr increments.
- Read acceptance:
  - Accepted iff rd_en && !empty, evaluated on the pre-edge state.
  - On acceptance: rptr increments.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: the read is accepted; the write is rejected (no write-through), so count = DEPTH-1.
  - Empty: the write is accepted; the read is rejected (no read-through), so count = 1.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. count never exceeds DEPTH and never underflows.
- Errors:
  - wr_error = 1 for exactly the cycle after each rejected write attempt (wr_en && full).
  - rd_error likewise for each rejected read (rd_en && empty).
  - A rejected request changes no pointer, count or memory.
  - Consecutive rejected cycles produce consecutive error cycles.
- FWFT=0 (standard mode):
  - Accepted read at edge N: rd_data = mem[old rptr] registered at edge N, and rd_valid = 1 for that one cycle.
  - rd_data holds its last value otherwise. Latency is one cycle.
- FWFT=1 (first-word-fall-through mode):
  - rd_data = mem[rptr], combinational from the memory array.
  - rd_valid = !empty.
  - The head word is visible the cycle after the write that made the FIFO non-empty.
  - rd_en pops the head; the next word appears after that edge.
  - rd_data is don't-care while empty.
- Thresholds: AF_THRESH and AE_THRESH must lie in 0..DEPTH. Equal-threshold configurations are legal and both flags may be asserted together.

Test Plan:
- Fill (DEPTH=16, FWFT=0): 16 writes of data i*2 after reset.
  - count steps 1..16; almost_full rises on the edge where count becomes 14.
  - full=1 after the 16th edge; almost_empty falls when count becomes 3; no wr_error.
- Overflow: 20 consecutive writes.
  - Exactly 4 single-cycle wr_error pulses, on cycles 17-20.
  - count stays 16; a subsequent 16-word read returns 0,2,...,30.
- Underflow: write 5 words, then 6 consecutive reads.
  - Data 0,2,4,6,8 with rd_valid pulses, then one rd_error pulse; empty=1, count=0.
- Simultaneous traffic at count=5: wr_en and rd_en high for 8 cycles.
  - count stays 5 throughout; reads return the oldest words in order.
- Simultaneous at boundaries:
  - From full, both asserted gives wr_error=1 and count=15.
  - From empty, both asserted gives rd_error=1 and count=1.
- Wrap-around and mode/reset:
  - Three passes of 10 writes/10 reads, data in order across the pointer wrap.
  - With FWFT=1: rd_data shows the first word with rd_valid=1 the cycle after the first write, before any rd_en.
  - rst asserted mid-stream: empty=1 and count=0 immediately, without a clock edge.
